// File: rtl/imem_pkg.sv
// Shared constants for the instruction fetch port: fault codes, the NOP
// word returned on faulting fetches, and the fault priority helper.
package imem_pkg;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Misalignment wins over range so a bad PC is reported as the more specific error.
  function automatic logic [1:0] fault_code(input logic misalign, input logic out_of_range);
    logic [1:0] code;
    code = FAULT_NONE;
    if (misalign) begin
      code = FAULT_MISALIGN;
    end else if (out_of_range) begin
      code = FAULT_RANGE;
    end
    return code;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one registered read
// port with read enable. The storage and the read register are not reset.
module imem_array #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  // The read register holds its value while re_i is low, which keeps a stalled
  // response stable even if the same word is rewritten behind it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Word-addressed instruction fetch port: valid/ready request and response
// handshake, one-cycle registered read, fault decode, flush and program load.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic [1:0]      rsp_fault,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [XLEN-1:0] prog_data,
  output logic [31:0]     fetch_count
);

  logic            accept;
  logic            rd_en;
  logic            misalign;
  logic            out_of_range;
  logic [1:0]      req_fault;
  logic [XLEN-1:0] mem_rdata;

  logic        rsp_valid_d, rsp_valid_q;
  logic [1:0]  rsp_fault_d, rsp_fault_q;
  logic        use_mem_d, use_mem_q;
  logic [31:0] fetch_count_d, fetch_count_q;

  always_comb begin
    req_ready = rst & ~prog_we & (~rsp_valid_q | rsp_ready);
    accept    = req_valid & req_ready;
  end

  // Any set bit above the word index means the word address is >= DEPTH_WORDS.
  always_comb begin
    misalign     = |req_addr[1:0];
    out_of_range = |req_addr[XLEN-1:AW+2];
    req_fault    = fault_code(misalign, out_of_range);
    rd_en        = accept & (req_fault == FAULT_NONE);
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_fault_d   = rsp_fault_q;
    use_mem_d     = use_mem_q;
    fetch_count_d = fetch_count_q;

    if (rsp_valid_q && (rsp_ready || flush)) begin
      rsp_valid_d = 1'b0;
    end

    // A request accepted alongside a flush still produces its response.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = req_fault;
      use_mem_d   = (req_fault == FAULT_NONE);
      if (fetch_count_q != 32'hFFFF_FFFF) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_fault_q   <= FAULT_NONE;
      use_mem_q     <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_fault_q   <= rsp_fault_d;
      use_mem_q     <= use_mem_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  imem_array #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .re_i    (rd_en),
    .raddr_i (req_addr[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  // The array read register is not reset; use_mem_q gates it so reset shows zero.
  always_comb begin
    if (rsp_fault_q != FAULT_NONE) begin
      rsp_instr = XLEN'(INSTR_NOP);
    end else if (use_mem_q) begin
      rsp_instr = mem_rdata;
    end else begin
      rsp_instr = '0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_fault   = rsp_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_imem_fetch_port;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image plus the single outstanding response.
  logic [31:0] mem_model [DEPTH];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [1:0]  m_fault;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  imem_fetch_port #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_instr   (rsp_instr),
    .rsp_fault   (rsp_fault),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void expect_for(input logic [31:0] a, output logic [31:0] ins,
                                     output logic [1:0] f);
    if (a % 4 != 0) begin
      f   = 2'b01;
      ins = 32'h0000_0013;
    end else if (a / 4 >= DEPTH) begin
      f   = 2'b10;
      ins = 32'h0000_0013;
    end else begin
      f   = 2'b00;
      ins = mem_model[a / 4];
    end
  endfunction

  function automatic logic model_ready();
    return rst && !prog_we && (!m_valid || rsp_ready);
  endfunction

  // Drive inputs, then compare every output with the model at the falling edge.
  task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic pw, input logic [9:0] pa, input logic [31:0] pd);
    req_valid = rv;
    req_addr  = ra;
    rsp_ready = rr;
    flush     = fl;
    prog_we   = pw;
    prog_addr = pa;
    prog_data = pd;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(model_ready()));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_instr", rsp_instr, m_instr);
      chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
    end
    chk("fetch_count", fetch_count, m_count);
  endtask

  // Apply the rising edge to the model, then let the DUT take it.
  task automatic advance();
    logic acc;
    acc = req_valid && model_ready();
    if (m_valid && (rsp_ready || flush)) m_valid = 1'b0;
    if (acc) begin
      m_valid = 1'b1;
      expect_for(req_addr, m_instr, m_fault);
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    end
    if (prog_we) mem_model[prog_addr] = prog_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, 10'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    m_valid = 1'b0; m_instr = '0; m_fault = '0; m_count = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'd0);
    chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("reset_fetch_count", fetch_count, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Preload the whole store with random words
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'(i), $urandom());
      advance();
    end

    // Load
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd0, 32'h0064_A423); advance();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd1, 32'h00B6_2423); advance();
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("load_first", rsp_instr, 32'h0064_A423);
    advance();
    idle(1'b1);
    chk("load_second", rsp_instr, 32'h00B6_2423);
    chk("load_fault", 32'(rsp_fault), 32'd0);
    chk("load_count", fetch_count, 32'd2);
    advance();

    // Stall
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_hold", rsp_instr, 32'h0064_A423);
      advance();
    end
    cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    idle(1'b1);
    chk("stall_next", rsp_instr, 32'h00B6_2423);
    advance();

    // Faults
    cycle(1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    cycle(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("fault_misalign", 32'(rsp_fault), 32'd1);
    chk("fault_misalign_nop", rsp_instr, 32'h0000_0013);
    advance();
    idle(1'b1);
    chk("fault_range", 32'(rsp_fault), 32'd2);
    chk("fault_range_nop", rsp_instr, 32'h0000_0013);
    advance();
    idle(1'b1); advance();

    // Flush
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'd0, 32'h0); advance();
    idle(1'b0);
    chk("flush_drop", 32'(rsp_valid), 32'd0);
    advance();
    cycle(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 10'd0, 32'h0); advance();
    idle(1'b1);
    chk("flush_new_valid", 32'(rsp_valid), 32'd1);
    chk("flush_new_instr", rsp_instr, 32'h00B6_2423);
    advance();

    // Program conflict
    cycle(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF);
    chk("prog_block", 32'(req_ready), 32'd0);
    advance();
    idle(1'b1);
    chk("prog_no_accept", 32'(rsp_valid), 32'd0);
    advance();
    cycle(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    idle(1'b1);
    chk("prog_readback", rsp_instr, 32'hDEAD_BEEF);
    advance();

    // Reset mid-stream
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_instr", rsp_instr, 32'd0);
    chk("midrst_count", fetch_count, 32'd0);
    m_valid = 1'b0;
    m_count = '0;
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    rst = 1'b1;
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); advance();
    idle(1'b1);
    chk("midrst_mem_kept", rsp_instr, 32'h0064_A423);
    chk("midrst_first_count", fetch_count, 32'd1);
    advance();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = $urandom();
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else if (r == 1) begin
        a = ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
      end else if (r == 2) begin
        a = 32'h0000_0FFC;
      end else begin
        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      end
      cycle(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            10'($urandom_range(0, DEPTH - 1)), $urandom());
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised, sequential successor to the combinational instruction ROM.
- Word-addressed instruction store with a synchronous registered read and a valid/ready fetch handshake, so the fetch stage can stall.
- Detects misaligned and out-of-range fetches, supports a redirect flush, and has a program-load write port so test programs (sw/lw sequences) are loaded at run time instead of hard-coded.
- Sits between the PC/fetch logic and the decode stage of the RISC-V core.

Parameters:
- XLEN, 32, address and instruction width in bits.
- DEPTH_WORDS, 1024, number of instruction words; power of two, minimum 4.
- AW, $clog2(DEPTH_WORDS), word-index width (derived, not overridable).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  fetch request can be accepted this cycle.
- req_addr  input  XLEN  byte address of the instruction (PC).
- flush  input  1  drop any pending response (branch redirect).
- rsp_valid  output  1  response holds a fetched instruction.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_instr  output  XLEN  fetched instruction word.
- rsp_fault  output  2  00 none, 01 misaligned, 10 out of range.
- prog_we  input  1  program-load write strobe.
- prog_addr  input  AW  word index to write.
- prog_data  input  XLEN  instruction word to write.
- fetch_count  output  32  saturating count of accepted fetches.

Behaviour:
- Reset (rst=0, asynchronous): rsp_valid=0, rsp_instr=0, rsp_fault=00, fetch_count=0. Memory contents are not cleared. req_ready is 0 while rst=0.
- Accept: a fetch is accepted when req_valid && req_ready.
  - req_ready = !prog_we && (!rsp_valid || rsp_ready).
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N with data from memory at N, i.e. one cycle.
- Hold: while rsp_valid && !rsp_ready, rsp_instr and rsp_fault hold stable and no new request is accepted.
- Back-to-back: with rsp_ready held at 1, one fetch completes per cycle and there are no bubbles.
- Retire: rsp_valid clears at an edge where rsp_valid && rsp_ready and no new request is accepted.
- Fault decode, evaluated at accept:
  - req_addr[1:0] != 0 gives fault 01.
  - Otherwise, req_addr[XLEN-1:2] >= DEPTH_WORDS gives fault 10.
  - Misaligned takes priority.
  - A faulting response carries rsp_instr = 32'h00000013 (NOP) and reads no memory.
- Word index: req_addr[AW+1:2].
- flush:
  - At the edge with flush=1, rsp_valid clears.
  - If a request is accepted in the same cycle, that new request still produces its response next cycle; only the older one is dropped.
  - flush does not affect fetch_count.
- Program port:
  - prog_we=1 writes prog_data to prog_addr at the edge and blocks fetch acceptance that cycle.
  - A pending response is unaffected: its data was latched earlier.
- fetch_count increments by 1 per accepted request, including faulting ones, and saturates at 32'hFFFFFFFF.
- Reset mid-operation: any pending response is lost immediately. After rst rises, the first accept can occur at the first edge.

Decomposition:
- Package imem_pkg:
  - fault code constants FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - INSTR_NOP=32'h00000013.
- Sub-module imem_array:
  - DEPTH_WORDS x XLEN storage, one synchronous read port with read enable, one synchronous write port.
  - No reset on the storage.
- Top level holds the handshake, fault decode, response register and counter.

Test Plan:
- Load: prog writes idx0=0x0064A423, idx1=0x00B62423; fetch addr 0x0 then 0x4 with rsp_ready=1. Expected: rsp_instr 0x0064A423 then 0x00B62423 on consecutive cycles, fault 00, fetch_count=2.
- Stall: fetch 0x0 with rsp_ready=0 for 3 cycles and req_valid held with addr 0x4. Expected: req_ready=0, rsp_instr holds 0x0064A423; when rsp_ready goes to 1, 0x00B62423 follows next cycle.
- Faults: fetch 0x2, then fetch 0x1000 with DEPTH_WORDS=1024. Expected: fault 01 then 10, rsp_instr=0x00000013 for both.
- Flush: flush=1 while the response for 0x0 is pending and no request. Expected: rsp_valid=0 next cycle. Flush together with a request for 0x4. Expected: next cycle rsp_valid=1, rsp_instr=0x00B62423.
- Program conflict: prog_we=1 with req_valid=1. Expected: req_ready=0 and no accept. Then fetch the written index. Expected: the new data is returned.
- Reset mid-stream: drop rst to 0 while rsp_valid=1. Expected: rsp_valid=0, rsp_instr=0 and fetch_count=0 immediately. Memory still returns 0x0064A423 at addr 0x0 after release.
